// File: rtl/rv32_bus_pkg.sv
// -----------------------------------------------------------------------------
// rv32_bus_pkg
// Shared definitions for the two-master Avalon-MM arbiter in front of the
// JTAG UART slave port.
//   state_t      : arbiter FSM states (IDLE, GNT0, GNT1)
//   AV_AW        : Avalon word-address width into the UART register map
//   AV_DW        : Avalon data width
//   TIMEOUT_DATA : read data returned to a master whose access timed out
// -----------------------------------------------------------------------------
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int unsigned AV_AW        = 3;
    localparam int unsigned AV_DW        = 32;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avmm_rr_pick.sv
// -----------------------------------------------------------------------------
// avmm_rr_pick
// Combinational 2-way round-robin picker.
// Ports:
//   i_req[1:0]   : request per master (bit n = master n)
//   i_last_grant : index of the master granted most recently
//   o_grant      : index of the chosen master (valid only with o_valid)
//   o_valid      : at least one request is present
// A lone request always wins; on a tie the master that was not granted last
// is chosen, so neither master can starve the other.
// -----------------------------------------------------------------------------
module avmm_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant = 1'b0;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/avmm_arbiter_2m.sv
// -----------------------------------------------------------------------------
// avmm_arbiter_2m
// Shares the single JTAG UART Avalon-MM slave port between two masters:
// master 0 is the RV32 load/store path, master 1 the display/debug dump engine.
//
// Ports:
//   clock, reset             : clock (rising edge), async active-high reset
//   mN_address/writedata     : master N request address and write data
//   mN_write/mN_read         : master N strobes, active high (write wins if both)
//   mN_readdata              : master N read data, valid in its completion cycle
//   mN_waitrequest           : master N stall, active high
//   mN_error                 : master N timeout abort pulse
//   av_address/av_writedata  : slave address and write data
//   av_write_n/av_read_n     : slave strobes, active low
//   av_readdata              : slave read data
//   av_waitrequest           : slave stall, active high
//   o_dbg_state              : current FSM state (rv32_bus_pkg::state_t encoding)
//
// Handshake: a master raises write or read with address/data and holds all of
// them stable while its waitrequest is high; the transfer completes in the
// cycle its waitrequest is low (read data valid in that same cycle). The slave
// side follows the same rule with av_waitrequest.
//
// Build option: define ARB_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// stalled cycles with an mN_error pulse and TIMEOUT_DATA as read data.
// -----------------------------------------------------------------------------
module avmm_arbiter_2m
    import rv32_bus_pkg::*;
#(
    parameter int unsigned AW             = AV_AW,
    parameter int unsigned DW             = AV_DW,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_writedata,
    input  logic          m0_write,
    input  logic          m0_read,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_waitrequest,
    output logic          m0_error,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_writedata,
    input  logic          m1_write,
    input  logic          m1_read,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_waitrequest,
    output logic          m1_error,
    output logic [AW-1:0] av_address,
    output logic [DW-1:0] av_writedata,
    output logic          av_write_n,
    output logic          av_read_n,
    input  logic [DW-1:0] av_readdata,
    input  logic          av_waitrequest,
    output logic [1:0]    o_dbg_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("avmm_arbiter_2m: TIMEOUT_CYCLES must be at least 1");
    end

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic          w_next_last_grant;

    logic [1:0]    w_req;
    logic          w_pick_idx;
    logic          w_pick_valid;

    logic          w_gnt_active;
    logic          w_sel;
    logic          w_sel_req;
    logic          w_sel_write;
    logic          w_sel_read;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          w_timeout;
    logic          w_drive;
    logic          w_done;
    logic          w_ack;
    logic [DW-1:0] w_ack_rdata;

    assign w_req = {m1_write | m1_read, m0_write | m0_read};

    avmm_rr_pick u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    // Which master (if any) owns the bus this cycle.
    always_comb begin
        w_gnt_active = 1'b0;
        w_sel        = 1'b0;
        case (r_state)
            GNT0: begin
                w_gnt_active = 1'b1;
                w_sel        = 1'b0;
            end
            GNT1: begin
                w_gnt_active = 1'b1;
                w_sel        = 1'b1;
            end
            default: begin
                w_gnt_active = 1'b0;
                w_sel        = 1'b0;
            end
        endcase
    end

    assign w_sel_write = w_sel ? m1_write     : m0_write;
    assign w_sel_read  = w_sel ? m1_read      : m0_read;
    assign w_sel_addr  = w_sel ? m1_address   : m0_address;
    assign w_sel_wdata = w_sel ? m1_writedata : m0_writedata;
    assign w_sel_req   = w_sel_write | w_sel_read;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned        CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_stall_cnt;

    // Held at zero in IDLE so every grant starts with a fresh count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!w_gnt_active) begin
            r_stall_cnt <= '0;
        end else if (w_drive && av_waitrequest) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_timeout = w_gnt_active & w_sel_req & (r_stall_cnt == CNT_MAX);
`else
    // No stall limit: a slave that never releases waitrequest holds the grant.
    assign w_timeout = 1'b0;
`endif

    // Strobes are only driven while the owner still requests; the timeout
    // cycle itself drops them so the slave sees the access abandoned.
    assign w_drive = w_gnt_active & w_sel_req & ~w_timeout;
    assign w_done  = w_drive & ~av_waitrequest;
    assign w_ack   = w_done | w_timeout;

    assign av_write_n   = ~(w_drive & w_sel_write);
    assign av_read_n    = ~(w_drive & w_sel_read & ~w_sel_write);
    assign av_address   = w_drive ? w_sel_addr  : '0;
    assign av_writedata = w_drive ? w_sel_wdata : '0;

    assign w_ack_rdata = w_timeout ? DW'(TIMEOUT_DATA) : av_readdata;

    assign m0_waitrequest = ~(w_ack & ~w_sel);
    assign m1_waitrequest = ~(w_ack &  w_sel);
    assign m0_readdata    = (w_ack & ~w_sel) ? w_ack_rdata : '0;
    assign m1_readdata    = (w_ack &  w_sel) ? w_ack_rdata : '0;
    assign m0_error       = w_timeout & ~w_sel;
    assign m1_error       = w_timeout &  w_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Every grant returns to IDLE, which forces a one-cycle bubble and lets
    // the round-robin picker re-arbitrate between transactions.
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state      = w_pick_idx ? GNT1 : GNT0;
                    w_next_last_grant = w_pick_idx;
                end
            end
            GNT0, GNT1: begin
                if (!w_sel_req || w_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_avmm_arbiter_2m.sv
module tb_avmm_arbiter_2m;
    import rv32_bus_pkg::*;

    localparam logic [1:0] SI  = IDLE;
    localparam logic [1:0] SG0 = GNT0;
    localparam logic [1:0] SG1 = GNT1;

    logic        clock;
    logic        reset;
    logic [2:0]  m0_address, m1_address, av_address;
    logic [31:0] m0_writedata, m1_writedata, av_writedata;
    logic        m0_write, m0_read, m1_write, m1_read;
    logic [31:0] m0_readdata, m1_readdata, av_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_error, m1_error;
    logic        av_write_n, av_read_n, av_waitrequest;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    avmm_arbiter_2m #(
        .AW             (3),
        .DW             (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_write       (m0_write),
        .m0_read        (m0_read),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m0_error       (m0_error),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_read        (m1_read),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .m1_error       (m1_error),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_write_n     (av_write_n),
        .av_read_n      (av_read_n),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        m0_wr, m0_rd;
        logic [2:0]  m0_a;
        logic [31:0] m0_d;
        logic        m1_wr, m1_rd;
        logic [2:0]  m1_a;
        logic [31:0] m1_d;
        logic        av_wait;
        logic [31:0] av_rd;
        logic [1:0]  e_state;
        logic        e_wn, e_rn;
        logic [2:0]  e_a;
        logic [31:0] e_wd;
        logic        e_m0_wait;
        logic [31:0] e_m0_rd;
        logic        e_m1_wait;
        logic [31:0] e_m1_rd;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input logic m0_wr, input logic m0_rd, input logic [2:0] m0_a, input logic [31:0] m0_d,
        input logic m1_wr, input logic m1_rd, input logic [2:0] m1_a, input logic [31:0] m1_d,
        input logic av_wait, input logic [31:0] av_rd,
        input logic [1:0] e_state, input logic e_wn, input logic e_rn, input logic [2:0] e_a,
        input logic [31:0] e_wd, input logic e_m0_wait, input logic [31:0] e_m0_rd,
        input logic e_m1_wait, input logic [31:0] e_m1_rd);
        vec_t v;
        v.m0_wr = m0_wr; v.m0_rd = m0_rd; v.m0_a = m0_a; v.m0_d = m0_d;
        v.m1_wr = m1_wr; v.m1_rd = m1_rd; v.m1_a = m1_a; v.m1_d = m1_d;
        v.av_wait = av_wait; v.av_rd = av_rd;
        v.e_state = e_state; v.e_wn = e_wn; v.e_rn = e_rn; v.e_a = e_a; v.e_wd = e_wd;
        v.e_m0_wait = e_m0_wait; v.e_m0_rd = e_m0_rd;
        v.e_m1_wait = e_m1_wait; v.e_m1_rd = e_m1_rd;
        vq.push_back(v);
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_write = 0; m0_read = 0; m0_address = 0; m0_writedata = 0;
        m1_write = 0; m1_read = 0; m1_address = 0; m1_writedata = 0;
        av_waitrequest = 1; av_readdata = 0;
    endtask

    task automatic apply(input vec_t v);
        m0_write = v.m0_wr; m0_read = v.m0_rd; m0_address = v.m0_a; m0_writedata = v.m0_d;
        m1_write = v.m1_wr; m1_read = v.m1_rd; m1_address = v.m1_a; m1_writedata = v.m1_d;
        av_waitrequest = v.av_wait; av_readdata = v.av_rd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d_state", i), 32'(o_dbg_state), 32'(v.e_state));
        chk($sformatf("v%0d_write_n", i), 32'(av_write_n), 32'(v.e_wn));
        chk($sformatf("v%0d_read_n", i), 32'(av_read_n), 32'(v.e_rn));
        chk($sformatf("v%0d_address", i), 32'(av_address), 32'(v.e_a));
        chk($sformatf("v%0d_writedata", i), av_writedata, v.e_wd);
        chk($sformatf("v%0d_m0_wait", i), 32'(m0_waitrequest), 32'(v.e_m0_wait));
        chk($sformatf("v%0d_m0_rdata", i), m0_readdata, v.e_m0_rd);
        chk($sformatf("v%0d_m1_wait", i), 32'(m1_waitrequest), 32'(v.e_m1_wait));
        chk($sformatf("v%0d_m1_rdata", i), m1_readdata, v.e_m1_rd);
        chk($sformatf("v%0d_errors", i), {30'd0, m1_error, m0_error}, 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        int completions;

        // m0 write addr 0 data 0x41, slave stalls two grant cycles
        add(1,0,0,32'h41, 0,0,0,0, 1,0,            SI, 1,1,0,0,       1,0, 1,0);
        add(1,0,0,32'h41, 0,0,0,0, 1,0,            SG0,0,1,0,32'h41,  1,0, 1,0);
        add(1,0,0,32'h41, 0,0,0,0, 1,0,            SG0,0,1,0,32'h41,  1,0, 1,0);
        add(1,0,0,32'h41, 0,0,0,0, 0,0,            SG0,0,1,0,32'h41,  0,0, 1,0);
        add(0,0,0,0,      0,0,0,0, 1,32'hFFFF_FFFF,SI, 1,1,0,0,       1,0, 1,0);
        // m1 read addr 1, zero-wait slave
        add(0,0,0,0, 0,1,1,0, 0,32'h0040_0000,     SI, 1,1,0,0,       1,0, 1,0);
        add(0,0,0,0, 0,1,1,0, 0,32'h0040_0000,     SG1,1,0,1,0,       1,0, 0,32'h0040_0000);
        add(0,0,0,0, 0,0,0,0, 1,0,                 SI, 1,1,0,0,       1,0, 1,0);
        // both request continuously, zero-wait: grants 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            add(1,0,2,32'hA0, 0,1,3,0, 0,32'h77,   SI, 1,1,0,0,       1,0, 1,0);
            add(1,0,2,32'hA0, 0,1,3,0, 0,32'h77,   SG0,0,1,2,32'hA0,  0,32'h77, 1,0);
            add(1,0,2,32'hA0, 0,1,3,0, 0,32'h77,   SI, 1,1,0,0,       1,0, 1,0);
            add(1,0,2,32'hA0, 0,1,3,0, 0,32'h77,   SG1,1,0,3,0,       1,0, 0,32'h77);
        end
        add(0,0,0,0, 0,0,0,0, 1,0,                 SI, 1,1,0,0,       1,0, 1,0);
        // m0 write and read together: only the write strobe
        add(1,1,4,32'h55, 0,0,0,0, 0,32'h5A,       SI, 1,1,0,0,       1,0, 1,0);
        add(1,1,4,32'h55, 0,0,0,0, 0,32'h5A,       SG0,0,1,4,32'h55,  0,32'h5A, 1,0);
        add(0,0,0,0, 0,0,0,0, 1,0,                 SI, 1,1,0,0,       1,0, 1,0);
        // m1 drops its request while granted: no completion, back to IDLE
        add(0,0,0,0, 1,0,5,32'h99, 1,0,            SI, 1,1,0,0,       1,0, 1,0);
        add(0,0,0,0, 0,0,0,0, 0,32'h66,            SG1,1,1,0,0,       1,0, 1,0);
        add(0,0,0,0, 0,0,0,0, 1,0,                 SI, 1,1,0,0,       1,0, 1,0);

        // reset state
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        chk("rst_state", 32'(o_dbg_state), 32'(SI));
        chk("rst_write_n", 32'(av_write_n), 32'd1);
        chk("rst_read_n", 32'(av_read_n), 32'd1);
        chk("rst_addr_data", {29'd0, av_address} | av_writedata, 32'd0);
        chk("rst_waits", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
        chk("rst_rdata", m0_readdata | m1_readdata, 32'd0);
        chk("rst_errors", {30'd0, m1_error, m0_error}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clock);
            #1 apply(vq[i]);
            #2 check_vec(i, vq[i]);
        end

        // reset in the 2nd cycle of a stalled m0 write
        @(posedge clock);
        #1;
        m0_write = 1; m0_address = 6; m0_writedata = 32'h12; av_waitrequest = 1;
        #2 chk("rsq_idle", 32'(o_dbg_state), 32'(SI));
        @(posedge clock);
        #3 chk("rsq_gnt_c1", 32'(av_write_n), 32'd0);
        @(posedge clock);
        #3 chk("rsq_gnt_c2", 32'(o_dbg_state), 32'(SG0));
        reset = 1'b1;
        #1;
        chk("rsq_write_n_async", 32'(av_write_n), 32'd1);
        chk("rsq_state_async", 32'(o_dbg_state), 32'(SI));
        chk("rsq_m0_wait", 32'(m0_waitrequest), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        #2 chk("rsq_post_rst_idle", 32'(o_dbg_state), 32'(SI));
        @(posedge clock);
        #3;
        chk("rsq_regrant_state", 32'(o_dbg_state), 32'(SG0));
        chk("rsq_regrant_write_n", 32'(av_write_n), 32'd0);
        chk("rsq_regrant_data", av_writedata, 32'h12);
        av_waitrequest = 0;
        #1 chk("rsq_regrant_done", 32'(m0_waitrequest), 32'd0);
        @(posedge clock);
        #1 idle_inputs();
        #2 chk("rsq_end_idle", 32'(o_dbg_state), 32'(SI));

        // slave holds waitrequest forever on an m0 read
        @(posedge clock);
        #1 m0_read = 1; m0_address = 7; av_waitrequest = 1;
        #2 chk("to_idle", 32'(o_dbg_state), 32'(SI));
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #3;
            chk($sformatf("to_stall%0d", k), {29'd0, m0_error, m0_waitrequest, av_read_n}, 32'b010);
        end
        @(posedge clock);
        #3;
        chk("to_error", 32'(m0_error), 32'd1);
        chk("to_wait", 32'(m0_waitrequest), 32'd0);
        chk("to_rdata", m0_readdata, 32'hDEAD_BEEF);
        chk("to_read_n", 32'(av_read_n), 32'd1);
        #1 m0_read = 0;
        @(posedge clock);
        #3;
        chk("to_back_idle", 32'(o_dbg_state), 32'(SI));
        chk("to_error_pulse", 32'(m0_error), 32'd0);
`else
        completions = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #3;
            if (!m0_waitrequest || m0_error) completions++;
        end
        chk("nto_no_completion", 32'(completions), 32'd0);
        chk("nto_still_gnt", 32'(o_dbg_state), 32'(SG0));
        av_waitrequest = 0; av_readdata = 32'h3C;
        #1;
        chk("nto_release_wait", 32'(m0_waitrequest), 32'd0);
        chk("nto_release_rdata", m0_readdata, 32'h3C);
        @(posedge clock);
        #1 idle_inputs();
`endif
        @(posedge clock);
        #3 chk("final_idle", 32'(o_dbg_state), 32'(SI));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avmm_arbiter_2m.md
Name: avmm_arbiter_2m

Overview:
- Two-master to one-slave Avalon-MM arbiter that shares the single JTAG UART Avalon port between two requesters.
- Master 0 is the RV32 core load/store path; master 1 is the display/debug dump engine.
- Round-robin grant with a 3-state FSM; completion is detected from av_waitrequest.
- Sits between the requesters and the slave-facing av_* signals, inside the core wrapper.

Parameters:
- AW, 3, Avalon address width (word address into the UART register map).
- DW, 32, data width.
- TIMEOUT_CYCLES, 1024, stall limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  AW  master 0 address.
- m0_writedata  in  DW  master 0 write data.
- m0_write  in  1  master 0 write request, active high.
- m0_read  in  1  master 0 read request, active high.
- m0_readdata  out  DW  master 0 read data.
- m0_waitrequest  out  1  master 0 stall, active high.
- m0_error  out  1  master 0 timeout abort pulse.
- m1_address, m1_writedata, m1_write, m1_read, m1_readdata, m1_waitrequest, m1_error: same as the m0_* ports, for master 1.
- av_address  out  AW  slave address.
- av_writedata  out  DW  slave write data.
- av_write_n  out  1  slave write strobe, active low.
- av_read_n  out  1  slave read strobe, active low.
- av_readdata  in  DW  slave read data.
- av_waitrequest  in  1  slave stall, active high.

Behaviour:
- Reset values (applied asynchronously):
  - state=IDLE, last_grant=1, so master 0 wins the first tie.
  - av_write_n=1, av_read_n=1, av_address=0, av_writedata=0.
  - mN_waitrequest=1, mN_readdata=0, mN_error=0.
- A request is reqN = mN_write | mN_read. If both are high, the write wins and the read is ignored for that transaction.
- FSM states are IDLE, GNT0 and GNT1.
- IDLE:
  - No bus strobes asserted.
  - If exactly one request is present, go to GNTn for that requester.
  - If both are present, grant the master that is not last_grant.
  - last_grant updates on entry to GNTn.
- GNTn, bus driving:
  - The av_* outputs are combinational muxes of master n's signals.
  - av_write_n=~mN_write; av_read_n=~(mN_read & ~mN_write).
  - Master n must hold address, data and strobes stable while its waitrequest is high.
- GNTn, completion:
  - Completion is a cycle with av_waitrequest=0.
  - In that same cycle, mN_waitrequest=0 and mN_readdata=av_readdata (combinational, zero-latency read).
  - Next state is IDLE, giving a mandatory one-cycle bubble between transactions.
- Grant latency: a request seen in IDLE at edge k drives the bus from cycle k+1. Minimum transaction is 2 cycles from request to waitrequest low.
- The non-granted master always sees waitrequest=1, readdata=0 and error=0.
- If master n drops its request while in GNTn (protocol violation), return to IDLE next edge with no completion signalled.
- Reset mid-transaction: strobes deassert immediately and asynchronously. The in-flight access is lost and no completion is given.
- A continuously requesting master cannot starve the other: after each completion, the other master wins the next tie.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A stall counter, $clog2(TIMEOUT_CYCLES)+1 bits, clears on GNTn entry and counts each GNTn cycle with av_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES, that cycle drives mN_waitrequest=0, mN_error=1 and mN_readdata=32'hDEAD_BEEF, with strobes still deasserted for that cycle. Next state is IDLE.
  - mN_error is a single-cycle pulse.
- Not defined: no counter exists and mN_error is tied to 0. A slave that holds waitrequest forever stalls the granted master forever.

Decomposition:
- Shared package (rv32_bus_pkg):
  - state enum {IDLE, GNT0, GNT1}.
  - Constants AV_AW=3, AV_DW=32, TIMEOUT_DATA=32'hDEAD_BEEF.
- One natural sub-module, avmm_rr_pick: a combinational 2-way round-robin picker with inputs req[1:0] and last_grant, and output grant index and valid.
- The FSM, muxing and timeout logic stay in the top module.

Test Plan:
- m0 write addr=0, data=32'h41, av_waitrequest low after 3 cycles -> av_write_n=0 and av_writedata=32'h41 for 3 cycles; m0_waitrequest low exactly in the completion cycle; IDLE bubble follows.
- m1 read addr=1, slave returns 32'h0040_0000 with waitrequest=0 on first grant cycle -> m1_readdata=32'h0040_0000 in that cycle, 2 cycles total.
- Both request continuously after reset, slave zero-wait -> grants alternate 0,1,0,1 over 4 transactions; m1 never sees waitrequest=0 while GNT0.
- Reset asserted in the 2nd cycle of a stalled m0 write -> av_write_n=1 immediately, state IDLE, no m0 completion; m0 regranted after reset release.
- With ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, av_waitrequest stuck at 1 -> after 8 stalled cycles m0_error=1 for one cycle and m0_readdata=32'hDEAD_BEEF; without the macro, no completion within 100 cycles.
- m0 asserts write and read together, data=32'h55 -> only av_write_n asserted; av_read_n stays 1.
